// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared widths, FSM state type and header packing for the router packet source
// Contents:
//   DATA_W, LEN_W, ADDR_W   byte, length-field and address-field widths
//   src_state_t             packet source FSM states
//   hdr_pack()              builds the header byte {len, addr}
package router_pkg;

    localparam int DATA_W = 8;
    localparam int LEN_W  = 6;
    localparam int ADDR_W = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_HDR,
        ST_PLD,
        ST_PAR,
        ST_GAP
    } src_state_t;

    function automatic logic [DATA_W-1:0] hdr_pack(input logic [LEN_W-1:0]  len,
                                                   input logic [ADDR_W-1:0] addr);
        return {len, addr};
    endfunction

endpackage

// File: rtl/router_src_buf.sv
// rtl/router_src_buf.sv - 64x8 payload buffer, synchronous write, asynchronous read
// Ports:
//   clk      in   write clock
//   wr_en    in   write strobe
//   wr_addr  in   write index
//   wr_data  in   write byte
//   rd_addr  in   read index
//   rd_data  out  byte at rd_addr (combinational)
// Contents are deliberately not reset.
module router_src_buf
    import router_pkg::*;
(
    input  logic              clk,
    input  logic              wr_en,
    input  logic [LEN_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [LEN_W-1:0]  rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**LEN_W];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/router_pkt_src.sv
// rtl/router_pkt_src.sv - buffered upstream packet source driving the 1x3 router input
// Ports:
//   clk        in   clock
//   rst        in   asynchronous active-low reset
//   req_valid  in   packet request strobe
//   req_addr   in   destination port 0..2
//   req_len    in   payload byte count 1..MAX_LEN
//   inj_err    in   (ROUTER_SRC_ERRINJ_EN only) corrupt parity bit 0 of this packet
//   req_ready  out  high in IDLE
//   req_err    out  one-cycle pulse on a rejected request
//   pl_valid   in   payload byte available
//   pl_data    in   payload byte
//   pl_ready   out  high in LOAD
//   busy       in   router busy, holds the presented byte
//   pkt_valid  out  router pkt_valid
//   data_out   out  router data_in
//   done       out  one-cycle pulse after the parity byte is accepted
// Optional feature macro: ROUTER_SRC_ERRINJ_EN
module router_pkt_src
    import router_pkg::*;
#(
    parameter int MAX_LEN    = 63,
    parameter int GAP_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
`ifdef ROUTER_SRC_ERRINJ_EN
    input  logic              inj_err,
`endif
    output logic              req_ready,
    output logic              req_err,
    input  logic              pl_valid,
    input  logic [DATA_W-1:0] pl_data,
    output logic              pl_ready,
    input  logic              busy,
    output logic              pkt_valid,
    output logic [DATA_W-1:0] data_out,
    output logic              done
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    src_state_t        state;
    logic [LEN_W-1:0]  len_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] parity;
    logic [LEN_W-1:0]  cnt;
    logic [GAP_W-1:0]  gap_cnt;

    logic              req_ok;
    logic              inj_bit;
    logic              buf_wr;
    logic [LEN_W-1:0]  buf_rd_addr;
    logic [DATA_W-1:0] buf_rd_data;

`ifdef ROUTER_SRC_ERRINJ_EN
    assign inj_bit = inj_err;
`else
    assign inj_bit = 1'b0;
`endif

    // Compare one bit wider so the upper bound is not range-constant at MAX_LEN=63.
    assign req_ok = (req_addr != 2'd3) && (req_len != '0) &&
                    ({1'b0, req_len} <= (LEN_W+1)'(MAX_LEN));

    assign buf_wr = (state == ST_LOAD) && pl_valid;

    // In PLD data_out already shows buf[cnt]; the next byte to present is buf[cnt+1].
    assign buf_rd_addr = (state == ST_PLD) ? cnt + LEN_ONE : cnt;

    router_src_buf u_buf (
        .clk     (clk),
        .wr_en   (buf_wr),
        .wr_addr (cnt),
        .wr_data (pl_data),
        .rd_addr (buf_rd_addr),
        .rd_data (buf_rd_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            len_q     <= '0;
            addr_q    <= '0;
            parity    <= '0;
            cnt       <= '0;
            gap_cnt   <= '0;
            req_ready <= 1'b0;
            req_err   <= 1'b0;
            pl_ready  <= 1'b0;
            pkt_valid <= 1'b0;
            data_out  <= '0;
            done      <= 1'b0;
        end else begin
            req_err <= 1'b0;
            done    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid) begin
                        if (req_ok) begin
                            len_q     <= req_len;
                            addr_q    <= req_addr;
                            // Injected error flips bit 0 up front; XOR order does not matter.
                            parity    <= hdr_pack(req_len, req_addr) ^ {{(DATA_W-1){1'b0}}, inj_bit};
                            cnt       <= '0;
                            req_ready <= 1'b0;
                            pl_ready  <= 1'b1;
                            state     <= ST_LOAD;
                        end else begin
                            req_err <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (pl_valid) begin
                        parity <= parity ^ pl_data;
                        if (cnt == len_q - LEN_ONE) begin
                            cnt       <= '0;
                            pl_ready  <= 1'b0;
                            pkt_valid <= 1'b1;
                            data_out  <= hdr_pack(len_q, addr_q);
                            state     <= ST_HDR;
                        end else begin
                            cnt <= cnt + LEN_ONE;
                        end
                    end
                end
                ST_HDR: begin
                    if (!busy) begin
                        data_out <= buf_rd_data;
                        state    <= ST_PLD;
                    end
                end
                ST_PLD: begin
                    if (!busy) begin
                        if (cnt == len_q - LEN_ONE) begin
                            data_out  <= parity;
                            pkt_valid <= 1'b0;
                            state     <= ST_PAR;
                        end else begin
                            cnt      <= cnt + LEN_ONE;
                            data_out <= buf_rd_data;
                        end
                    end
                end
                ST_PAR: begin
                    if (!busy) begin
                        done     <= 1'b1;
                        data_out <= '0;
                        gap_cnt  <= '0;
                        if (GAP_CYCLES == 0) begin
                            req_ready <= 1'b1;
                            state     <= ST_IDLE;
                        end else begin
                            state <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                        req_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_router_pkt_src.sv
// tb/tb_router_pkt_src.sv - scoreboard testbench for router_pkt_src
module tb_router_pkt_src;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic [1:0] req_addr;
    logic [5:0] req_len;
    logic       req_ready;
    logic       req_err;
    logic       pl_valid;
    logic [7:0] pl_data;
    logic       pl_ready;
    logic       busy;
    logic       pkt_valid;
    logic [7:0] data_out;
    logic       done;
`ifdef ROUTER_SRC_ERRINJ_EN
    logic       inj_err;
`endif

    always #5 clk = ~clk;

    router_pkt_src dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_len   (req_len),
`ifdef ROUTER_SRC_ERRINJ_EN
        .inj_err   (inj_err),
`endif
        .req_ready (req_ready),
        .req_err   (req_err),
        .pl_valid  (pl_valid),
        .pl_data   (pl_data),
        .pl_ready  (pl_ready),
        .busy      (busy),
        .pkt_valid (pkt_valid),
        .data_out  (data_out),
        .done      (done)
    );

    int         checks   = 0;
    int         failures = 0;
    logic [8:0] exp_q[$];   // {pkt_valid, byte} expected per accepted byte
    logic [8:0] obs_q[$];   // {pkt_valid, byte} observed per accepted byte
    logic [7:0] hold_q[$];  // data_out seen on each stalled cycle
    bit         timeout;
    bit         early;
    bit         hdr_now;
    logic       done_seen;
    logic       done_after;
    int         gap_n;

    task automatic send_req(input logic [1:0] a, input logic [5:0] l);
        int g = 0;
        while (req_ready !== 1'b1 && g < 50) begin @(posedge clk); #1; g++; end
        if (g >= 50) timeout = 1;
        req_valid = 1'b1; req_addr = a; req_len = l;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic load(input logic [7:0] p[$], input bit toggle);
        int g = 0;
        early = 0;
        while (pl_ready !== 1'b1 && g < 50) begin @(posedge clk); #1; g++; end
        if (g >= 50) timeout = 1;
        foreach (p[i]) begin
            pl_valid = 1'b1; pl_data = p[i];
            @(posedge clk); #1;
            if (i != p.size() - 1) begin
                if (pkt_valid) early = 1;
                if (toggle) begin
                    pl_valid = 1'b0;
                    @(posedge clk); #1;
                    if (pkt_valid) early = 1;
                end
            end
        end
        pl_valid = 1'b0;
        hdr_now  = pkt_valid;
    endtask

    // Records every accepted byte; stalls stream index stall_idx for stall_n cycles.
    task automatic capture(input int stall_idx, input int stall_n);
        int idx = 0;
        int stalls = stall_n;
        int g = 0;
        obs_q.delete(); hold_q.delete();
        done_seen = 1'b0; done_after = 1'b0; gap_n = 0;
        while (pkt_valid !== 1'b1 && g < 300) begin @(posedge clk); #1; g++; end
        if (g >= 300) begin timeout = 1; return; end
        forever begin
            if (idx == stall_idx && stalls > 0) begin
                busy = 1'b1;
                hold_q.push_back(data_out);
                stalls--;
            end else begin
                busy = 1'b0;
                obs_q.push_back({pkt_valid, data_out});
                idx++;
                if (!pkt_valid) break;
            end
            @(posedge clk); #1;
            g++;
            if (g >= 300) begin timeout = 1; busy = 1'b0; return; end
        end
        busy = 1'b0;
        @(posedge clk); #1;
        done_seen = done;
        @(posedge clk); #1;
        done_after = done;
        gap_n = 1;
        while (req_ready !== 1'b1 && gap_n < 20) begin @(posedge clk); #1; gap_n++; end
    endtask

    task automatic do_packet(input logic [1:0] a, input logic [5:0] l, input logic [7:0] p[$],
                             input bit toggle, input int stall_idx, input int stall_n, input logic inj);
        logic [7:0] par;
        exp_q.delete();
        timeout = 0;
        par = {l, a} ^ {7'd0, inj};
        exp_q.push_back({1'b1, l, a});
        foreach (p[i]) begin
            exp_q.push_back({1'b1, p[i]});
            par ^= p[i];
        end
        exp_q.push_back({1'b0, par});
`ifdef ROUTER_SRC_ERRINJ_EN
        inj_err = inj;
`endif
        send_req(a, l);
`ifdef ROUTER_SRC_ERRINJ_EN
        inj_err = 1'b0;
`endif
        load(p, toggle);
        capture(stall_idx, stall_n);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        checks++;
        if ({req_ready, req_err, pl_ready, pkt_valid, done, data_out} !== 13'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %b required 0", {req_ready, req_err, pl_ready, pkt_valid, done, data_out});
        end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready: got %b required 1", req_ready); end
    endtask

    task automatic test_basic;
        logic [7:0] p[$];
        logic [8:0] e, o;
        for (int i = 1; i <= 8; i++) p.push_back(8'(i));
        do_packet(2'd0, 6'd8, p, 0, -1, 0, 1'b0);
        checks++;
        if (timeout) begin failures++; $display("FAIL basic_timeout: got timeout required completion"); end
        checks++;
        if (obs_q.size() < 1 || obs_q[0] !== 9'h120) begin
            failures++; $display("FAIL basic_header: got %h required 120", obs_q.size() ? obs_q[0] : 9'h0);
        end
        checks++;
        if (obs_q.size() < 1 || obs_q[obs_q.size()-1] !== 9'h028) begin
            failures++; $display("FAIL basic_parity: got %h required 028", obs_q.size() ? obs_q[obs_q.size()-1] : 9'h0);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.size() ? obs_q.pop_front() : 9'bx;
            checks++;
            if (o !== e) begin failures++; $display("FAIL basic_stream: got %h required %h", o, e); end
        end
        checks++;
        if (done_seen !== 1'b1 || done_after !== 1'b0) begin
            failures++; $display("FAIL basic_done_pulse: got %b%b required 10", done_seen, done_after);
        end
        checks++;
        if (gap_n != 2) begin failures++; $display("FAIL basic_gap: got %0d required 2", gap_n); end
    endtask

    task automatic test_stall;
        logic [7:0] p[$];
        logic [8:0] e, o;
        for (int i = 0; i < 14; i++) p.push_back(8'($urandom_range(0, 255)));
        do_packet(2'd1, 6'd14, p, 0, 5, 3, 1'b0);
        checks++;
        if (timeout) begin failures++; $display("FAIL stall_timeout: got timeout required completion"); end
        checks++;
        if (obs_q.size() < 1 || obs_q[0] !== 9'h139) begin
            failures++; $display("FAIL stall_header: got %h required 139", obs_q.size() ? obs_q[0] : 9'h0);
        end
        checks++;
        if (hold_q.size() != 3) begin failures++; $display("FAIL stall_hold_len: got %0d required 3", hold_q.size()); end
        foreach (hold_q[i]) begin
            checks++;
            if (hold_q[i] !== p[4]) begin failures++; $display("FAIL stall_hold: got %h required %h", hold_q[i], p[4]); end
        end
        checks++;
        if (obs_q.size() != 16) begin failures++; $display("FAIL stall_count: got %0d required 16", obs_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.size() ? obs_q.pop_front() : 9'bx;
            checks++;
            if (o !== e) begin failures++; $display("FAIL stall_stream: got %h required %h", o, e); end
        end
    endtask

    task automatic test_slow_load;
        logic [7:0] p[$];
        logic [8:0] e, o;
        int nvalid = 0;
        for (int i = 0; i < 17; i++) p.push_back(8'($urandom_range(0, 255)));
        do_packet(2'd2, 6'd17, p, 1, -1, 0, 1'b0);
        checks++;
        if (timeout) begin failures++; $display("FAIL slow_timeout: got timeout required completion"); end
        checks++;
        if (early || !hdr_now) begin failures++; $display("FAIL slow_header_timing: got early=%0d hdr_now=%0d required 0 1", early, hdr_now); end
        foreach (obs_q[i]) if (obs_q[i][8]) nvalid++;
        checks++;
        if (nvalid != 18) begin failures++; $display("FAIL slow_no_bubble: got %0d valid cycles required 18", nvalid); end
        checks++;
        if (obs_q.size() < 1 || obs_q[0] !== 9'h146) begin
            failures++; $display("FAIL slow_header: got %h required 146", obs_q.size() ? obs_q[0] : 9'h0);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.size() ? obs_q.pop_front() : 9'bx;
            checks++;
            if (o !== e) begin failures++; $display("FAIL slow_stream: got %h required %h", o, e); end
        end
    endtask

    task automatic test_reject;
        for (int k = 0; k < 2; k++) begin
            int g = 0;
            while (req_ready !== 1'b1 && g < 50) begin @(posedge clk); #1; g++; end
            req_valid = 1'b1;
            req_addr  = (k == 0) ? 2'd3 : 2'd0;
            req_len   = (k == 0) ? 6'd5 : 6'd0;
            @(posedge clk); #1;
            req_valid = 1'b0;
            checks++;
            if ({req_err, req_ready, pkt_valid, pl_ready} !== 4'b1100) begin
                failures++; $display("FAIL reject_pulse_%0d: got %b required 1100", k, {req_err, req_ready, pkt_valid, pl_ready});
            end
            @(posedge clk); #1;
            checks++;
            if ({req_err, req_ready, pkt_valid, pl_ready} !== 4'b0100) begin
                failures++; $display("FAIL reject_after_%0d: got %b required 0100", k, {req_err, req_ready, pkt_valid, pl_ready});
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] p[$];
        logic [8:0] e, o;
        for (int i = 0; i < 8; i++) p.push_back(8'($urandom_range(0, 255)));
        timeout = 0;
        send_req(2'd0, 6'd8);
        load(p, 0);
        busy = 1'b0;
        for (int i = 0; i < 5; i++) begin @(posedge clk); #1; end
        checks++;
        if ({pkt_valid, data_out} !== {1'b1, p[4]}) begin
            failures++; $display("FAIL rstmid_before: got %h required %h", {pkt_valid, data_out}, {1'b1, p[4]});
        end
        #1 rst = 1'b0;
        #1;
        checks++;
        if ({pkt_valid, data_out, done, req_ready} !== 11'd0) begin
            failures++; $display("FAIL rstmid_async: got %h required 0", {pkt_valid, data_out, done, req_ready});
        end
        @(posedge clk); #1;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({req_ready, pkt_valid, pl_ready} !== 3'b100) begin
            failures++; $display("FAIL rstmid_idle: got %b required 100", {req_ready, pkt_valid, pl_ready});
        end
        p.delete();
        for (int i = 0; i < 8; i++) p.push_back(8'($urandom_range(0, 255)));
        do_packet(2'd0, 6'd8, p, 0, -1, 0, 1'b0);
        checks++;
        if (timeout) begin failures++; $display("FAIL rstmid_timeout: got timeout required completion"); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.size() ? obs_q.pop_front() : 9'bx;
            checks++;
            if (o !== e) begin failures++; $display("FAIL rstmid_stream: got %h required %h", o, e); end
        end
    endtask

`ifdef ROUTER_SRC_ERRINJ_EN
    task automatic test_errinj;
        logic [7:0] p[$];
        logic [8:0] e, o;
        for (int i = 1; i <= 8; i++) p.push_back(8'(i));
        do_packet(2'd0, 6'd8, p, 0, -1, 0, 1'b1);
        checks++;
        if (obs_q.size() < 1 || obs_q[obs_q.size()-1] !== 9'h029) begin
            failures++; $display("FAIL errinj_parity: got %h required 029", obs_q.size() ? obs_q[obs_q.size()-1] : 9'h0);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.size() ? obs_q.pop_front() : 9'bx;
            checks++;
            if (o !== e) begin failures++; $display("FAIL errinj_stream: got %h required %h", o, e); end
        end
    endtask
`endif

    initial begin
        rst = 1'b0; req_valid = 1'b0; req_addr = '0; req_len = '0;
        pl_valid = 1'b0; pl_data = '0; busy = 1'b0;
`ifdef ROUTER_SRC_ERRINJ_EN
        inj_err = 1'b0;
`endif
        test_reset;
        test_basic;
        test_stall;
        test_slow_load;
        test_reject;
        test_reset_mid;
`ifdef ROUTER_SRC_ERRINJ_EN
        test_errinj;
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/router_pkt_src.md
Name: router_pkt_src

Overview:
- Upstream packet source for the 1x3 router.
- Takes a packet request (dest addr, payload length) plus a payload byte stream, buffers the whole payload, then drives the router input as header, payload, parity.
- Uses the router's pkt_valid/data_in/busy protocol.
- Buffering first means pkt_valid never carries a bubble mid-packet.

Parameters:
MAX_LEN, 63, largest accepted payload length; must be <= 63 (6-bit length field)
GAP_CYCLES, 2, idle cycles with pkt_valid=0 inserted after each parity byte

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, asynchronous, active-low
req_valid  in  1  packet request strobe
req_addr  in  2  destination port 0..2
req_len  in  6  payload byte count
req_ready  out  1  high only in IDLE
req_err  out  1  one-cycle pulse: request rejected
pl_valid  in  1  payload byte available
pl_data  in  8  payload byte
pl_ready  out  1  high only in LOAD
busy  in  1  router busy; current byte is held while high
pkt_valid  out  1  router pkt_valid
data_out  out  8  router data_in
done  out  1  one-cycle pulse after the parity byte is accepted

Behaviour:
- Reset (async, rst=0): all outputs 0, state IDLE, counters and parity cleared. Payload buffer contents are not reset.
- Reset mid-packet: pkt_valid drops immediately and no parity byte is sent.
- FSM states: IDLE, LOAD, HDR, PLD, PAR, GAP.
- IDLE:
  - req_ready=1.
  - On req_valid with req_addr!=3 and 1<=req_len<=MAX_LEN: latch addr/len, set parity={len,addr}, set cnt=0, go to LOAD.
  - Otherwise, if req_valid: pulse req_err next cycle and stay in IDLE.
- LOAD:
  - pl_ready=1.
  - Each edge with pl_valid=1: buf[cnt]<=pl_data, parity^=pl_data, cnt++.
  - When byte len-1 is taken: go to HDR, load data_out={len,addr}, set pkt_valid=1, so header is visible the cycle after the last load.
- Byte acceptance rule: a presented byte is accepted at a rising edge where busy=0. While busy=1, data_out and pkt_valid hold unchanged.
- HDR: on accept, go to PLD with cnt=0 and data_out=buf[0].
- PLD: on accept, cnt++ and present buf[cnt+1]. After byte len-1 is accepted, go to PAR with data_out=parity and pkt_valid=0.
- PAR: on accept, pulse done, set data_out=0, go to GAP.
- GAP: count GAP_CYCLES cycles, then return to IDLE.
- Parity: 8-bit XOR of header and all payload bytes. The parity byte itself is sent with pkt_valid=0.
- Outputs pkt_valid, data_out, done, req_err, req_ready and pl_ready are all registered.
- pl_valid outside LOAD and req_valid outside IDLE are ignored.
- Counters are 6-bit; no wrap is possible because len<=63.
- busy is sampled in every state but only stalls HDR, PLD and PAR.

Optional Feature:
ROUTER_SRC_ERRINJ_EN
- Defined: adds input inj_err (1 bit), sampled with an accepted request. When set, bit 0 of that packet's parity byte is inverted, so the router must flag errr.
- Undefined: port absent; parity is always correct.

Decomposition:
- Shared package router_pkg: DATA_W=8, LEN_W=6, ADDR_W=2, state enum src_state_t, header-pack function {len,addr}.
- One sub-module: router_src_buf, a 64x8 register array with synchronous write and asynchronous read, write port driven in LOAD, read port indexed by cnt.

Test Plan:
1. req addr=0, len=8, payload 8'h01..8'h08, busy=0 throughout:
   - Header 8'h20, then the 8 bytes on consecutive cycles with pkt_valid=1.
   - Parity byte 8'h20^08h-xor(01..08)=8'h28 with pkt_valid=0.
   - done pulses; req_ready rises again after 2 gap cycles.
2. req addr=1, len=14, busy forced high for 3 cycles during payload byte 5: data_out holds byte 5 unchanged for all 3 cycles; header is 8'h39; no byte lost or duplicated.
3. req addr=2, len=17, payload streamed with pl_valid toggling every other cycle: header 8'h46 is not presented until all 17 bytes are loaded; the output then runs 18 consecutive cycles with pkt_valid=1 and no bubble.
4. req addr=3 (or len=0): req_err is a single pulse, req_ready stays 1, pkt_valid stays 0.
5. rst asserted during PLD at byte 4 of 8: pkt_valid=0 and data_out=0 immediately. After release, state is IDLE and a new addr=0, len=8 packet sends cleanly.
6. With ROUTER_SRC_ERRINJ_EN defined, inj_err=1 on the case 1 request: parity byte is 8'h29; connected router asserts errr.
